// File: rtl/down_timer.sv
// down_timer: loadable, prescaled down-counter with one-shot and auto-reload modes.
// A start from IDLE captures load value, prescale and mode; the count decrements
// once every prescale+1 RUN cycles and flags terminal count with a one-cycle tc.

module down_timer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  input  logic [PW-1:0]    prescale,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done,
  output logic             zero_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  state_e           state_q;
  state_e           state_d;

  logic [PW-1:0]    presc_q;
  logic [PW-1:0]    presc_d;
  logic [PW-1:0]    cap_q;
  logic [PW-1:0]    cap_d;
  logic [WIDTH-1:0] load_q;
  logic [WIDTH-1:0] load_d;
  logic             auto_q;
  logic             auto_d;

  logic [WIDTH-1:0] count_d;
  logic             busy_d;
  logic             tc_d;
  logic             done_d;
  logic             zero_err_d;

  logic             tick_c;
  logic [PW-1:0]    presc_next_c;

  // Tick fires in the cycle the prescaler sits at the captured cap.
  assign tick_c = (presc_q == cap_q);

  // Prescaler advance, saturating at the cap so it can never wrap.
  assign presc_next_c = (presc_q < cap_q) ? presc_q + PW'(1) : cap_q;

  // Next-state and next-output logic; abort beats start, start beats pause.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    cap_d      = cap_q;
    load_d     = load_q;
    auto_d     = auto_q;
    count_d    = count;
    tc_d       = 1'b0;
    done_d     = done;
    zero_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (load_val != '0) begin
            load_d  = load_val;
            cap_d   = prescale;
            auto_d  = auto_reload;
            count_d = load_val;
            presc_d = '0;
            done_d  = 1'b0;
            state_d = ST_RUN;
          end else begin
            zero_err_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (abort) begin
          count_d = '0;
          presc_d = '0;
          state_d = ST_IDLE;
        end else if (pause && !start) begin
          // Freeze prescaler and count; a tick landing here is dropped.
          state_d = ST_PAUSE;
        end else if (tick_c) begin
          presc_d = '0;
          if (count > WIDTH'(1)) begin
            count_d = count - WIDTH'(1);
          end else if (count == WIDTH'(1)) begin
            tc_d = 1'b1;
            if (auto_q) begin
              // Reload directly from 1 so zero is never observable.
              count_d = load_q;
            end else begin
              count_d = '0;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end else begin
          presc_d = presc_next_c;
        end
      end

      ST_PAUSE: begin
        if (abort) begin
          count_d = '0;
          presc_d = '0;
          state_d = ST_IDLE;
        end else if (start) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        count_d = '0;
        presc_d = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, captured configuration and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      cap_q    <= '0;
      load_q   <= '0;
      auto_q   <= 1'b0;
      count    <= '0;
      busy     <= 1'b0;
      tc       <= 1'b0;
      done     <= 1'b0;
      zero_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      cap_q    <= cap_d;
      load_q   <= load_d;
      auto_q   <= auto_d;
      count    <= count_d;
      busy     <= busy_d;
      tc       <= tc_d;
      done     <= done_d;
      zero_err <= zero_err_d;
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// Testbench for down_timer: expected outputs are queued as stimulus is driven
// and compared one entry per clock edge, sampled 1 time unit after the edge.

module tb_down_timer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned PW    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             pause;
  logic             abort;
  logic             auto_reload;
  logic [WIDTH-1:0] load_val;
  logic [PW-1:0]    prescale;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             done;
  logic             zero_err;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string      tag;
    logic [7:0] count;
    logic       busy;
    logic       tc;
    logic       done;
    logic       zerr;
    bit         en;
  } exp_t;

  exp_t sb_q[$];

  down_timer #(.WIDTH(WIDTH), .PW(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pause       (pause),
    .abort       (abort),
    .auto_reload (auto_reload),
    .load_val    (load_val),
    .prescale    (prescale),
    .count       (count),
    .busy        (busy),
    .tc          (tc),
    .done        (done),
    .zero_err    (zero_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_exp(input string tag, input logic [7:0] c, input logic b,
                          input logic t, input logic d, input logic z);
    exp_t e;
    e.tag = tag; e.count = c; e.busy = b; e.tc = t; e.done = d; e.zerr = z; e.en = 1'b1;
    sb_q.push_back(e);
  endtask

  task automatic push_skip();
    exp_t e;
    e.tag = ""; e.count = '0; e.busy = 1'b0; e.tc = 1'b0; e.done = 1'b0; e.zerr = 1'b0;
    e.en = 1'b0;
    sb_q.push_back(e);
  endtask

  // Advance one clock edge and compare against the oldest queued expectation.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'(0), 32'(1));
    end else begin
      e = sb_q.pop_front();
      if (e.en) begin
        check({e.tag, ".count"},    32'(count),    32'(e.count));
        check({e.tag, ".busy"},     32'(busy),     32'(e.busy));
        check({e.tag, ".tc"},       32'(tc),       32'(e.tc));
        check({e.tag, ".done"},     32'(done),     32'(e.done));
        check({e.tag, ".zero_err"}, 32'(zero_err), 32'(e.zerr));
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; auto_reload = 1'b0;
    load_val = '0; prescale = '0;

    // Asynchronous reset without any clock edge.
    #1 rst = 1'b0;
    #1;
    check("rst.count",    32'(count),    32'(0));
    check("rst.busy",     32'(busy),     32'(0));
    check("rst.tc",       32'(tc),       32'(0));
    check("rst.done",     32'(done),     32'(0));
    check("rst.zero_err", 32'(zero_err), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    push_exp("idle", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0); tick();

    // One-shot, prescale 0; start held a second cycle must not restart.
    load_val = 8'd5; prescale = 4'd0; auto_reload = 1'b0; start = 1'b1;
    push_exp("os_start", 8'd5, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    push_exp("os_restart_ign", 8'd4, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    start = 1'b0; load_val = 8'd9;
    for (int i = 3; i >= 1; i--) begin
      push_exp("os_cnt", 8'(i), 1'b1, 1'b0, 1'b0, 1'b0); tick();
    end
    push_exp("os_tc", 8'd0, 1'b0, 1'b1, 1'b1, 1'b0); tick();
    push_exp("os_after", 8'd0, 1'b0, 1'b0, 1'b1, 1'b0); tick();

    // Auto-reload, load 3, prescale 1: each value held two cycles.
    load_val = 8'd3; prescale = 4'd1; auto_reload = 1'b1; start = 1'b1;
    push_exp("ar_start", 8'd3, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    start = 1'b0; auto_reload = 1'b0; load_val = 8'd0;
    for (int t = 1; t <= 11; t++) begin
      int n;
      n = t / 2;
      push_exp("ar_cnt", 8'(3 - (n % 3)), 1'b1,
               ((t % 2 == 0) && (n % 3 == 0) && (n > 0)), 1'b0, 1'b0);
      tick();
    end

    // Abort together with start on a reload tick: abort wins, no tc.
    abort = 1'b1; start = 1'b1;
    push_exp("abort_tick", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    abort = 1'b0; start = 1'b0;
    push_exp("idle_after_abort", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0); tick();

    // Rejected start with load_val == 0.
    load_val = 8'd0; start = 1'b1;
    push_exp("zero_err", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    start = 1'b0;
    push_exp("zero_err_gone", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0); tick();

    // Pause at count 3 / prescaler 1, hold ten cycles, resume.
    load_val = 8'd4; prescale = 4'd2; auto_reload = 1'b0; start = 1'b1;
    push_exp("ps_start", 8'd4, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    start = 1'b0;
    push_exp("ps_run", 8'd4, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    push_exp("ps_run", 8'd4, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    push_exp("ps_run", 8'd3, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    push_exp("ps_run", 8'd3, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_exp("ps_frozen", 8'd3, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    end
    pause = 1'b0; start = 1'b1;
    push_exp("ps_resume", 8'd3, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    start = 1'b0;
    push_exp("ps_r1", 8'd3, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    push_exp("ps_r2", 8'd2, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    push_exp("ps_r3", 8'd2, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    push_exp("ps_r4", 8'd2, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    push_exp("ps_r5", 8'd1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    push_exp("ps_r6", 8'd1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    push_exp("ps_r7", 8'd1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    push_exp("ps_tc", 8'd0, 1'b0, 1'b1, 1'b1, 1'b0); tick();

    // Reset asserted between edges while running at count 0x37.
    load_val = 8'h40; prescale = 4'd0; start = 1'b1;
    push_exp("rs_start", 8'h40, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      push_exp("rs_cnt", 8'(8'h40 - i), 1'b1, 1'b0, 1'b0, 1'b0); tick();
    end
    #2 rst = 1'b0;
    #1;
    check("async_rst.count", 32'(count), 32'(0));
    check("async_rst.busy",  32'(busy),  32'(0));
    check("async_rst.tc",    32'(tc),    32'(0));
    check("async_rst.done",  32'(done),  32'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    push_exp("idle_after_rst", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0); tick();

    // Boundary: load 255, prescale 15.
    load_val = 8'd255; prescale = 4'd15; auto_reload = 1'b0; start = 1'b1;
    push_exp("bd_start", 8'd255, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    start = 1'b0;
    for (int t = 1; t <= 4081; t++) begin
      case (t)
        15:      push_exp("bd_pre_first", 8'd255, 1'b1, 1'b0, 1'b0, 1'b0);
        16:      push_exp("bd_first_dec", 8'd254, 1'b1, 1'b0, 1'b0, 1'b0);
        4079:    push_exp("bd_pre_tc", 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        4080:    push_exp("bd_tc", 8'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        4081:    push_exp("bd_after", 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        default: push_skip();
      endcase
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
